// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - memory-stage opcode encodings, bus FSM state type and decode helper
package instruction_pkg;

   localparam logic [3:0] MINST_LB   = 4'b0000;
   localparam logic [3:0] MINST_LH   = 4'b0001;
   localparam logic [3:0] MINST_LW   = 4'b0010;
   localparam logic [3:0] MINST_LBU  = 4'b0100;
   localparam logic [3:0] MINST_LHU  = 4'b0101;
   localparam logic [3:0] MINST_SB   = 4'b1000;
   localparam logic [3:0] MINST_SH   = 4'b1001;
   localparam logic [3:0] MINST_SW   = 4'b1010;
   localparam logic [3:0] MINST_NONE = 4'b1100;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_REQ  = 2'd1,
      M_RESP = 2'd2
   } mem_state_t;

   // Only the eight defined load/store codes touch the bus; everything else is not a memory op.
   function automatic logic minst_is_mem(input logic [3:0] minst);
      case (minst)
         MINST_LB, MINST_LH, MINST_LW, MINST_LBU, MINST_LHU,
         MINST_SB, MINST_SH, MINST_SW: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication / byte enables and load byte-half extraction with extension
module lsu_align (
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  lb;
   logic [15:0] lh;

   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase

      lb = load_word[{addr_lo, 3'b000} +: 8];
      lh = addr_lo[1] ? load_word[31:16] : load_word[15:0];
      case (funct3)
         3'b000:  load_data = {{24{lb[7]}}, lb};
         3'b001:  load_data = {{16{lh[15]}}, lh};
         3'b100:  load_data = {24'h000000, lb};
         3'b101:  load_data = {16'h0000, lh};
         default: load_data = load_word;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - M stage: registers execution result, runs one data-bus access per instruction, drives writeback
module memory_access
   import instruction_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rdm_v,
   input  logic [4:0]  rd,
   input  logic [3:0]  minst,
   input  logic [31:0] rd_data,
   input  logic [31:0] rs2_data,
   output logic        hazard_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_v,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign,
   output logic [31:0] misalign_addr
);

   logic        m_rdm_v_q, m_rdm_v_d;
   logic [4:0]  m_rd_q, m_rd_d;
   logic [3:0]  m_minst_q, m_minst_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_sdata_q, m_sdata_d;
   mem_state_t  state_q, state_d;
   logic        wb_v_q, wb_v_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic [31:0] misalign_addr_q, misalign_addr_d;

   logic        m_mem, m_store, m_nonmem, m_aligned, m_go, resp_done;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_data;

   lsu_align u_align (
      .funct3     (m_minst_q[2:0]),
      .addr_lo    (m_addr_q[1:0]),
      .store_data (m_sdata_q),
      .load_word  (dmem_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   always_comb begin
      m_mem    = minst_is_mem(m_minst_q);
      m_store  = m_minst_q[3];
      m_nonmem = (m_minst_q[3:2] == 2'b11);
      case (m_minst_q[1:0])
         2'b01:   m_aligned = !CHECK_ALIGN || !m_addr_q[0];
         2'b10:   m_aligned = !CHECK_ALIGN || (m_addr_q[1:0] == 2'b00);
         default: m_aligned = 1'b1;
      endcase
      m_go = m_mem && m_aligned;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= M_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         M_IDLE, M_REQ: begin
            if (!m_go)          state_d = M_IDLE;
            else if (!dmem_gnt) state_d = M_REQ;
            else                state_d = m_store ? M_IDLE : M_RESP;
         end
         M_RESP:  if (dmem_rvalid) state_d = M_IDLE;
         default: state_d = M_IDLE;
      endcase
   end

   // Stall is released combinationally on the completing cycle so the next op is captured on that edge.
   always_comb begin
      resp_done  = (state_q == M_RESP) && dmem_rvalid;
      dmem_req   = m_go && (state_q != M_RESP);
      dmem_we    = dmem_req && m_store;
      dmem_addr  = dmem_req ? {m_addr_q[31:2], 2'b00} : 32'h0;
      dmem_be    = dmem_req ? lane_be : 4'h0;
      dmem_wdata = dmem_we ? lane_wdata : 32'h0;
      hazard_m   = m_go && !(m_store && dmem_gnt) && !resp_done;

      wb_v_d    = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (resp_done) begin
         wb_v_d = m_rdm_v_q;
         if (m_rdm_v_q) begin
            wb_rd_d   = m_rd_q;
            wb_data_d = load_data;
         end
      end else if (m_nonmem) begin
         wb_v_d = m_rdm_v_q;
         if (m_rdm_v_q) begin
            wb_rd_d   = m_rd_q;
            wb_data_d = m_addr_q;
         end
      end

      misalign_d      = m_mem && !m_aligned;
      misalign_addr_d = misalign_d ? m_addr_q : misalign_addr_q;

      m_rdm_v_d = m_rdm_v_q;
      m_rd_d    = m_rd_q;
      m_minst_d = m_minst_q;
      m_addr_d  = m_addr_q;
      m_sdata_d = m_sdata_q;
      if (!hazard_m) begin
         m_rdm_v_d = rdm_v;
         m_rd_d    = rd;
         m_minst_d = minst;
         m_addr_d  = rd_data;
         m_sdata_d = rs2_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rdm_v_q       <= 1'b0;
         m_rd_q          <= 5'd0;
         m_minst_q       <= MINST_NONE;
         m_addr_q        <= 32'h0;
         m_sdata_q       <= 32'h0;
         wb_v_q          <= 1'b0;
         wb_rd_q         <= 5'd0;
         wb_data_q       <= 32'h0;
         misalign_q      <= 1'b0;
         misalign_addr_q <= 32'h0;
      end else begin
         m_rdm_v_q       <= m_rdm_v_d;
         m_rd_q          <= m_rd_d;
         m_minst_q       <= m_minst_d;
         m_addr_q        <= m_addr_d;
         m_sdata_q       <= m_sdata_d;
         wb_v_q          <= wb_v_d;
         wb_rd_q         <= wb_rd_d;
         wb_data_q       <= wb_data_d;
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   assign wb_v          = wb_v_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign misalign      = misalign_q;
   assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - randomized M-stage bench with byte-level memory reference model and bus responder
module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rdm_v;
   logic [4:0]  rd;
   logic [3:0]  minst;
   logic [31:0] rd_data, rs2_data;
   logic        hazard_m, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_v;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;
   logic [31:0] misalign_addr;

   always #5 clk = ~clk;

   memory_access #(.CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .rdm_v(rdm_v), .rd(rd), .minst(minst),
      .rd_data(rd_data), .rs2_data(rs2_data), .hazard_m(hazard_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign), .misalign_addr(misalign_addr)
   );

   typedef struct { logic v; logic [4:0] rd; logic [3:0] minst; logic [31:0] a; logic [31:0] d; } instr_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; bit is_load; } wb_t;
   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cyc; } txn_t;

   instr_t      stim_q[$];
   wb_t         wb_q[$];
   txn_t        txn_q[$];
   logic [31:0] mis_q[$];
   int          mis_cyc_q[$];
   logic [7:0]  ref_mem [0:63];
   logic [31:0] bus_mem [0:15];

   int checks = 0, passed = 0, cycle = 0;
   int fix_wait = -1, fix_rv = -1, reads = 0;
   int gnt_cnt, rv_cnt, last_wait, last_rv, last_rv_cycle, req_len, last_req_len;
   int prev_acc, prev_kind;
   bit req_active, rv_pend, spur_en, pending, pend_real, txn_open, prev_valid;
   logic [31:0] rv_addr;
   instr_t cur;
   txn_t   cur_txn;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
   endtask

   task automatic push(input logic v, input logic [4:0] r, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d);
      instr_t x;
      x.v = v; x.rd = r; x.minst = m; x.a = a; x.d = d;
      stim_q.push_back(x);
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      bus_mem[a[5:2]] = w;
      for (int i = 0; i < 4; i++) ref_mem[{a[5:2], 2'b00} + i] = w[8*i +: 8];
   endtask

   // Reference: memory as a byte array, loads/stores as byte sequences at the effective address.
   task automatic model(input instr_t ins, input int n, output int ek);
      int nb, base;
      logic [31:0] v;
      txn_t t;
      nb = 1 << ins.minst[1:0];
      case (ins.minst)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101: ek = 1;
         4'b1000, 4'b1001, 4'b1010:                   ek = 2;
         default:                                     ek = 0;
      endcase
      if (ins.minst[3:2] == 2'b11) begin
         if (ins.v) wb_q.push_back('{ins.rd, ins.a, n + 2, 1'b0});
      end else if (ek != 0 && (ins.a % nb) != 0) begin
         mis_q.push_back(ins.a);
         mis_cyc_q.push_back(n + 2);
         ek = 0;
      end else if (ek != 0) begin
         base = int'(ins.a[5:0]);
         t.we = (ek == 2); t.addr = ins.a & 32'hFFFF_FFFC; t.be = 4'h0; t.wdata = 32'h0; t.cyc = n + 1;
         if (ek == 2) begin
            for (int i = 0; i < nb; i++) begin
               t.be[int'(ins.a[1:0]) + i] = 1'b1;
               ref_mem[base + i] = ins.d[8*i +: 8];
            end
            for (int k = 0; k < 4; k++) t.wdata[8*k +: 8] = ins.d[8*(k % nb) +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
            if (!ins.minst[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            if (ins.v) wb_q.push_back('{ins.rd, v, 0, 1'b1});
         end
         txn_q.push_back(t);
      end
   endtask

   task automatic bus_drive();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom();
      if (rv_pend) begin
         if (rv_cnt == 0) begin
            dmem_rvalid = 1'b1; dmem_rdata = bus_mem[rv_addr[5:2]];
            rv_pend = 1'b0; last_rv_cycle = cycle;
         end else rv_cnt--;
      end
      if (dmem_req) begin
         if (!req_active) begin
            req_active = 1'b1;
            gnt_cnt = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
            last_wait = gnt_cnt;
         end
         if (gnt_cnt == 0) begin
            dmem_gnt = 1'b1; req_active = 1'b0;
            if (dmem_we) begin
               for (int i = 0; i < 4; i++)
                  if (dmem_be[i]) bus_mem[dmem_addr[5:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
            end else begin
               rv_pend = 1'b1; rv_addr = dmem_addr; reads++;
               rv_cnt = (fix_rv >= 0) ? fix_rv : int'($urandom_range(0, 2));
               last_rv = rv_cnt;
            end
         end else gnt_cnt--;
      end
      if (spur_en && !dmem_rvalid && !rv_pend && !dmem_req && $urandom_range(0, 5) == 0)
         dmem_rvalid = 1'b1;
   endtask

   task automatic monitor();
      wb_t w;
      int ek, eg;
      if (reset_n) begin
         if (wb_v) begin
            if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
            else begin
               w = wb_q.pop_front();
               check("wb_rd", 32'(wb_rd), 32'(w.rd));
               check("wb_data", wb_data, w.data);
               check("wb_cycle", cycle, w.is_load ? last_rv_cycle + 1 : w.cyc);
            end
         end
         if (misalign) begin
            if (mis_q.size() == 0) check("mis_unexpected", 32'd1, 32'd0);
            else begin
               check("mis_addr", misalign_addr, mis_q.pop_front());
               check("mis_cycle", cycle, mis_cyc_q.pop_front());
            end
         end
         if (dmem_req) begin
            if (!txn_open) begin
               if (txn_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
               else begin
                  cur_txn = txn_q.pop_front();
                  check("req_cycle", cycle, cur_txn.cyc);
               end
               txn_open = 1'b1; req_len = 0;
            end
            req_len++;
            check("req_we", 32'(dmem_we), 32'(cur_txn.we));
            check("req_addr", dmem_addr, cur_txn.addr);
            if (cur_txn.we) begin
               check("req_be", 32'(dmem_be), 32'(cur_txn.be));
               check("req_wdata", dmem_wdata, cur_txn.wdata);
            end
            if (dmem_gnt) begin txn_open = 1'b0; last_req_len = req_len; end
         end
         if (!hazard_m) begin
            if (prev_valid) begin
               case (prev_kind)
                  1:       eg = 2 + last_wait + last_rv;
                  2:       eg = 1 + last_wait;
                  default: eg = 1;
               endcase
               check("issue_gap", cycle - prev_acc, eg);
            end
            model(cur, cycle, ek);
            prev_kind = ek; prev_acc = cycle; prev_valid = 1'b1; pending = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cycle++;
      #1;
      if (!pending) begin
         pend_real = (stim_q.size() > 0);
         if (pend_real) cur = stim_q.pop_front();
         else begin cur.v = 1'b0; cur.rd = 5'd0; cur.minst = 4'b1100; cur.a = 32'h0; cur.d = 32'h0; end
         pending = 1'b1;
      end
      rdm_v = cur.v; rd = cur.rd; minst = cur.minst; rd_data = cur.a; rs2_data = cur.d;
      bus_drive();
      @(negedge clk);
      monitor();
   endtask

   function automatic bit idle();
      return stim_q.size() == 0 && !(pending && pend_real) && wb_q.size() == 0 &&
             txn_q.size() == 0 && mis_q.size() == 0 && !rv_pend && !txn_open;
   endfunction

   task automatic drain();
      for (int g = 0; g < 3000 && !idle(); g++) step();
      check("drain_done", 32'(idle()), 32'd1);
      repeat (2) step();
   endtask

   initial begin
      int r0;
      instr_t x;
      reset_n = 1'b0; rdm_v = 1'b0; rd = 5'd0; minst = 4'b1100; rd_data = 32'h0; rs2_data = 32'h0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom());
      repeat (2) step();
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_hazard", 32'(hazard_m), 32'd0);
      check("rst_wb_v", 32'(wb_v), 32'd0);
      check("rst_wb_rd", 32'(wb_rd), 32'd0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_mis_addr", misalign_addr, 32'h0);
      check("rst_addr", dmem_addr, 32'h0);
      reset_n = 1'b1;

      fix_wait = 0; fix_rv = 0;
      push(1'b1, 5'd5, 4'b1100, 32'h1234, 32'h0);
      push(1'b0, 5'd0, 4'b1000, 32'h103, 32'hAB);
      drain();
      check("alu_rd", 32'(wb_rd), 32'd5);
      check("alu_data", wb_data, 32'h1234);

      fix_wait = 3;
      set_word(32'h200, 32'h0080_0000);
      push(1'b1, 5'd7, 4'b0000, 32'h202, 32'h0);
      drain();
      check("lb_req_hold", last_req_len, 32'd4);
      check("lb_data", wb_data, 32'hFFFF_FF80);

      fix_wait = 0; fix_rv = 1;
      set_word(32'h200, 32'h8001_0000);
      push(1'b1, 5'd8, 4'b0101, 32'h202, 32'h0);
      drain();
      check("lhu_data", wb_data, 32'h0000_8001);
      r0 = reads;
      push(1'b0, 5'd0, 4'b0010, 32'h204, 32'h0);
      push(1'b1, 5'd9, 4'b0010, 32'h301, 32'h0);
      drain();
      check("x0_read", reads - r0, 32'd1);
      check("x0_no_wb", wb_data, 32'h0000_8001);
      check("mis_hold", misalign_addr, 32'h301);

      fix_rv = 3;
      push(1'b1, 5'd10, 4'b0010, 32'h208, 32'h0);
      for (int g = 0; g < 20 && !rv_pend; g++) step();
      check("rst_gnt", 32'(rv_pend), 32'd1);
      step();
      check("resp_stall", 32'(hazard_m), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_req", 32'(dmem_req), 32'd0);
      check("rst_mid_hazard", 32'(hazard_m), 32'd0);
      wb_q.delete(); txn_q.delete(); mis_q.delete(); mis_cyc_q.delete();
      txn_open = 1'b0; req_active = 1'b0; prev_valid = 1'b0;
      step();
      reset_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         check("rst_no_wb", 32'(wb_v), 32'd0);
         check("rst_idle", 32'(hazard_m), 32'd0);
      end
      push(1'b1, 5'd11, 4'b1100, 32'h55, 32'h0);
      drain();
      check("post_rst_alu", wb_data, 32'h55);

      fix_wait = -1; fix_rv = -1; spur_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         x.v = ($urandom_range(0, 7) != 0); x.rd = 5'($urandom()); x.a = $urandom(); x.d = $urandom();
         case ($urandom_range(0, 9))
            0, 1, 2: x.minst = {2'b11, 2'($urandom())};
            3, 4, 5: case ($urandom_range(0, 4))
                        0: x.minst = 4'b0000; 1: x.minst = 4'b0001; 2: x.minst = 4'b0010;
                        3: x.minst = 4'b0100; default: x.minst = 4'b0101;
                     endcase
            6, 7, 8: x.minst = {2'b10, 2'($urandom_range(0, 2))};
            default: case ($urandom_range(0, 3))
                        0: x.minst = 4'b0011; 1: x.minst = 4'b0110;
                        2: x.minst = 4'b0111; default: x.minst = 4'b1011;
                     endcase
         endcase
         if ($urandom_range(0, 3) != 0) x.a[1:0] = 2'b00;
         stim_q.push_back(x);
      end
      drain();
      for (int w = 0; w < 16; w++)
         check("mem_word", bus_mem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
